// File: rtl/alu_pkg.sv
// Shared definitions for the ALU shift path: shift-op codes and sequencer states.
package alu_pkg;

    localparam logic [1:0] OP_LSR = 2'b00;
    localparam logic [1:0] OP_ASR = 2'b01;
    localparam logic [1:0] OP_LSL = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_e;

endpackage

// File: rtl/alu_shift_sequencer_shift_step.sv
// Single-bit shift stage: one 1-bit LSR/ASR/LSL/ROR step plus the bit shifted out.
module unsigned_right_shift #(
    parameter int W = 8
) (
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         cout_o
);
    assign data_o = {1'b0, data_i[W-1:1]};
    assign cout_o = data_i[0];
endmodule

module signed_right_shift #(
    parameter int W = 8
) (
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         cout_o
);
    assign data_o = {data_i[W-1], data_i[W-1:1]};
    assign cout_o = data_i[0];
endmodule

module shift_step
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] data_i,
    input  logic [1:0]   op_i,
    output logic [W-1:0] data_o,
    output logic         cout_o
);
    logic [W-1:0] lsr_data, asr_data;
    logic         lsr_c, asr_c;

    unsigned_right_shift #(.W(W)) u_lsr (
        .data_i (data_i),
        .data_o (lsr_data),
        .cout_o (lsr_c)
    );

    signed_right_shift #(.W(W)) u_asr (
        .data_i (data_i),
        .data_o (asr_data),
        .cout_o (asr_c)
    );

    always_comb begin
        data_o = lsr_data;
        cout_o = lsr_c;
        case (op_i)
            OP_LSR: begin
                data_o = lsr_data;
                cout_o = lsr_c;
            end
            OP_ASR: begin
                data_o = asr_data;
                cout_o = asr_c;
            end
            OP_LSL: begin
                data_o = {data_i[W-2:0], 1'b0};
                cout_o = data_i[W-1];
            end
            default: begin
                data_o = {data_i[0], data_i[W-1:1]};
                cout_o = data_i[0];
            end
        endcase
    end
endmodule

// File: rtl/alu_shift_sequencer.sv
// Multi-cycle shift sequencer: one 1-bit step per clock with start/busy/done handshake.
module alu_shift_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand,
    input  logic [AMT_W-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);
    state_e             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [1:0]         op_q, op_d;
    logic [AMT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q, carry_d;
    logic               zero_q, zero_d;

    logic [WIDTH-1:0]   step_data;
    logic               step_c;

    shift_step #(.W(WIDTH)) u_step (
        .data_i (work_q),
        .op_i   (op_q),
        .data_o (step_data),
        .cout_o (step_c)
    );

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    work_d = operand;
                    op_d   = op;
                    cnt_d  = amount;
                    if (amount == '0) begin
                        state_d  = S_DONE;
                        result_d = operand;
                        carry_d  = 1'b0;
                        zero_d   = (operand == '0);
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                work_d = step_data;
                cnt_d  = cnt_q - 1'b1;
                // Final step: outputs are captured from the step result directly.
                if (cnt_q == AMT_W'(1)) begin
                    state_d  = S_DONE;
                    result_d = step_data;
                    carry_d  = step_c;
                    zero_d   = (step_data == '0);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            work_q   <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign carry  = carry_q;
    assign zero   = zero_q;
endmodule
